// File: rtl/sram_burst_master.sv
// sram_burst_master: accepts word-addressed read/write bursts of 1..16 beats
// and drives a single-port SRAM (combinational read, byte-enabled write).
// Write data and SRAM strobes are a zero-latency pass-through of the WD
// stream. Read data goes through one output register with back-pressure.
// Optional macro SRAM_MASTER_BOUND_ERR_EN adds an ERR output. With it, a
// burst that would run past the top of the address space is accepted,
// answered with an ERR+DONE pulse, and never touches the SRAM.

module sram_burst_master #(
    parameter  int unsigned DATAWIDTH = 32,
    parameter  int unsigned ADDRWIDTH = 16,
    localparam int unsigned LEN_W     = 4,
    localparam int unsigned BE_W      = DATAWIDTH / 8
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic                 REQ_WRITE,
    input  logic [ADDRWIDTH-1:0] REQ_ADDR,
    input  logic [LEN_W-1:0]     REQ_LEN,
    input  logic [BE_W-1:0]      REQ_BE,
    input  logic                 WD_VALID,
    output logic                 WD_READY,
    input  logic [DATAWIDTH-1:0] WD_DATA,
    output logic                 RD_VALID,
    input  logic                 RD_READY,
    output logic [DATAWIDTH-1:0] RD_DATA,
    output logic                 RD_LAST,
    output logic                 DONE,
    output logic [ADDRWIDTH-1:0] ADDRESS,
    output logic                 CS,
    output logic [BE_W-1:0]      WE,
    output logic [DATAWIDTH-1:0] WDATA,
    input  logic [DATAWIDTH-1:0] RDATA
`ifdef SRAM_MASTER_BOUND_ERR_EN
    ,
    output logic                 ERR
`endif
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic [BE_W-1:0]        be_q, be_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [DATAWIDTH-1:0]   rd_data_q, rd_data_d;
    logic                   rd_last_q, rd_last_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

`ifdef SRAM_MASTER_BOUND_ERR_EN
    localparam logic [ADDRWIDTH:0] ADDR_SPAN = (ADDRWIDTH+1)'(1) << ADDRWIDTH;
    logic [ADDRWIDTH:0] req_end;
    logic               bound_err;

    // One past the last word the request would touch, checked against the space size
    assign req_end   = {1'b0, REQ_ADDR} + (ADDRWIDTH+1)'(REQ_LEN) + (ADDRWIDTH+1)'(1);
    assign bound_err = req_end > ADDR_SPAN;
    assign ERR       = err_q;
`endif

    assign RD_VALID = rd_valid_q;
    assign RD_DATA  = rd_data_q;
    assign RD_LAST  = rd_last_q;
    assign DONE     = done_q;

    // State and datapath registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            be_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            be_q       <= be_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic and SRAM/handshake outputs
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        be_d       = be_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        REQ_READY  = 1'b0;
        WD_READY   = 1'b0;
        CS         = 1'b0;
        WE         = '0;
        WDATA      = '0;
        ADDRESS    = '0;

        case (state_q)
            IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    addr_d = REQ_ADDR;
                    cnt_d  = REQ_LEN;
                    be_d   = REQ_BE;
`ifdef SRAM_MASTER_BOUND_ERR_EN
                    if (bound_err) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else
`endif
                    begin
                        state_d = REQ_WRITE ? WRITE : READ;
                    end
                end
            end

            WRITE: begin
                WD_READY = 1'b1;
                ADDRESS  = addr_q;
                if (WD_VALID) begin
                    // An all-zero byte mask consumes the beat without selecting the SRAM
                    if (be_q != '0) begin
                        CS    = 1'b1;
                        WE    = be_q;
                        WDATA = WD_DATA;
                    end
                    addr_d = addr_q + ADDRWIDTH'(1);
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            READ: begin
                ADDRESS = addr_q;
                // Issue only when the output register is free or being drained this cycle
                if (!rd_valid_q || RD_READY) begin
                    CS         = 1'b1;
                    rd_data_d  = RDATA;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (cnt_q == '0);
                    addr_d     = addr_q + ADDRWIDTH'(1);
                    cnt_d      = cnt_q - LEN_W'(1);
                    if (cnt_q == '0) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (RD_READY) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    state_d    = IDLE;
                    done_d     = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_burst_master.sv
// tb_sram_burst_master: randomized and directed bursts against a burst-level
// reference model (expected SRAM access list, expected read beats, reference
// memory image) with a per-cycle compare process.

module tb_sram_burst_master;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } acc_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } rd_t;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        REQ_VALID, REQ_READY, REQ_WRITE;
    logic [15:0] REQ_ADDR;
    logic [3:0]  REQ_LEN, REQ_BE;
    logic        WD_VALID, WD_READY;
    logic [31:0] WD_DATA;
    logic        RD_VALID, RD_READY, RD_LAST;
    logic [31:0] RD_DATA;
    logic        DONE;
    logic [15:0] ADDRESS;
    logic        CS;
    logic [3:0]  WE;
    logic [31:0] WDATA, RDATA;
    logic        ERR;

    sram_burst_master dut (
        .CLK(CLK), .RSTn(RSTn),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .REQ_BE(REQ_BE),
        .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
        .DONE(DONE), .ADDRESS(ADDRESS), .CS(CS), .WE(WE), .WDATA(WDATA),
        .RDATA(RDATA)
`ifdef SRAM_MASTER_BOUND_ERR_EN
        , .ERR(ERR)
`endif
    );

`ifndef SRAM_MASTER_BOUND_ERR_EN
    assign ERR = 1'b0;
`endif

    always #5 CLK = ~CLK;

    // SRAM model attached to the DUT, plus the reference image the model predicts
    logic [31:0] sram    [0:65535];
    logic [31:0] ref_mem [0:65535];

    assign RDATA = (CS && WE == 4'h0) ? sram[ADDRESS] : 32'hDEAD_BEEF;

    always @(posedge CLK) begin
        if (CS) begin
            for (int b = 0; b < 4; b++)
                if (WE[b]) sram[ADDRESS][8*b +: 8] = WDATA[8*b +: 8];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Model state shared by driver and compare process
    acc_t        exp_acc[$];
    rd_t         exp_rd[$];
    logic [31:0] wd_q[$];
    logic [15:0] cs_log[$];
    logic [31:0] rd_log[$];
    int          rd_cyc[$];
    int          wr_beats_left = 0;
    bit          busy_wr = 0, busy_rd = 0, acc_wr = 0, acc_ovf = 0;
    bit          burst_done = 0, rd_first_pending = 0, stall_prev = 0;
    int          cyc = 0, done_due = -100, err_due = -100, accept_cyc = 0;
    int          cs_cnt = 0, err_cnt = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    // Per-cycle comparison of DUT outputs against the burst model
    always @(negedge CLK) begin
        if (RSTn) begin
            acc_t e;
            rd_t  r;
            cyc++;
            chk("done", 32'(DONE), 32'(cyc == done_due));
            chk("req_ready", 32'(REQ_READY), 32'(!(busy_wr || busy_rd)));
            chk("wd_ready", 32'(WD_READY), 32'(busy_wr));
`ifdef SRAM_MASTER_BOUND_ERR_EN
            chk("err", 32'(ERR), 32'(cyc == err_due));
            if (ERR) err_cnt++;
`endif
            if (CS) begin
                cs_cnt++;
                cs_log.push_back(ADDRESS);
                if (exp_acc.size() == 0) begin
                    chk("spurious_cs", 32'(CS), 32'h0);
                end else begin
                    e = exp_acc.pop_front();
                    chk("cs_addr", 32'(ADDRESS), 32'(e.addr));
                    chk("cs_we", 32'(WE), 32'(e.we));
                    if (e.we != 4'h0) chk("cs_wdata", WDATA, e.data);
                end
            end else begin
                chk("idle_we", 32'(WE), 32'h0);
                chk("idle_wdata", WDATA, 32'h0);
            end
            if (stall_prev) begin
                chk("stall_valid", 32'(RD_VALID), 32'h1);
                chk("stall_data", RD_DATA, prev_data);
                chk("stall_last", 32'(RD_LAST), 32'(prev_last));
            end
            if (RD_VALID && !RD_READY) chk("stall_cs", 32'(CS), 32'h0);
            stall_prev = RD_VALID && !RD_READY;
            prev_data  = RD_DATA;
            prev_last  = RD_LAST;
            if (rd_first_pending && RD_VALID) begin
                chk("rd_latency", 32'(cyc - accept_cyc), 32'd2);
                rd_first_pending = 0;
            end
            if (RD_VALID && RD_READY) begin
                rd_log.push_back(RD_DATA);
                rd_cyc.push_back(cyc);
                if (exp_rd.size() == 0) begin
                    chk("spurious_rd", 32'(RD_VALID), 32'h0);
                end else begin
                    r = exp_rd.pop_front();
                    chk("rd_data", RD_DATA, r.data);
                    chk("rd_last", 32'(RD_LAST), 32'(r.last));
                    if (r.last) begin
                        busy_rd  = 0;
                        done_due = cyc + 1;
                    end
                end
            end
            if (WD_VALID && WD_READY && wr_beats_left > 0) begin
                wr_beats_left--;
                if (wr_beats_left == 0) begin
                    busy_wr  = 0;
                    done_due = cyc + 1;
                end
            end
            if (REQ_VALID && REQ_READY) begin
                accept_cyc = cyc;
                if (acc_ovf) begin
                    done_due = cyc + 1;
                    err_due  = cyc + 1;
                end else if (acc_wr) begin
                    busy_wr = 1;
                end else begin
                    busy_rd          = 1;
                    rd_first_pending = 1;
                end
            end
            if (DONE) burst_done = 1;
        end
    end

    // Build expectations for one burst; only the first n_exp write beats reach the SRAM
    task automatic model_burst(input bit wr, input logic [15:0] a, input logic [3:0] len,
                               input logic [3:0] be, input bit rnd, input logic [31:0] dbase,
                               input int n_exp);
        acc_wr  = wr;
        acc_ovf = 0;
`ifdef SRAM_MASTER_BOUND_ERR_EN
        acc_ovf = (32'(a) + 32'(len) + 32'd1) > 32'h1_0000;
`endif
        wr_beats_left = (wr && !acc_ovf) ? int'(len) + 1 : 0;
        cs_cnt = 0; err_cnt = 0; burst_done = 0;
        cs_log.delete(); rd_log.delete(); rd_cyc.delete();
        if (!acc_ovf) begin
            for (int i = 0; i <= int'(len); i++) begin
                logic [15:0] ad;
                logic [31:0] d;
                ad = a + 16'(i);
                if (wr) begin
                    d = rnd ? $urandom : dbase + 32'(i);
                    wd_q.push_back(d);
                    if (be != 4'h0 && i < n_exp) begin
                        exp_acc.push_back('{ad, be, d});
                        ref_mem[ad] = merge(ref_mem[ad], d, be);
                    end
                end else begin
                    exp_acc.push_back('{ad, 4'h0, 32'h0});
                    exp_rd.push_back('{ref_mem[ad], 1'(i == int'(len))});
                end
            end
        end
    endtask

    task automatic do_accept(input bit wr, input logic [15:0] a, input logic [3:0] len,
                             input logic [3:0] be);
        bit ok;
        ok = 0;
        REQ_VALID = 1; REQ_WRITE = wr; REQ_ADDR = a; REQ_LEN = len; REQ_BE = be;
        for (int g = 0; g < 50; g++) begin
            @(negedge CLK);
            if (REQ_READY) begin
                ok = 1;
                break;
            end
        end
        chk("accept_timeout", 32'(ok), 32'h1);
        @(posedge CLK);
        #1;
        REQ_VALID = 0; REQ_WRITE = 1'($urandom); REQ_ADDR = 16'($urandom);
        REQ_LEN = 4'($urandom); REQ_BE = 4'($urandom);
    endtask

    // rd_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic run_burst(input bit wr, input logic [15:0] a, input logic [3:0] len,
                             input logic [3:0] be, input bit rnd, input logic [31:0] dbase,
                             input int wd_pct, input int rd_mode);
        int k;
        bit hs;
        model_burst(wr, a, len, be, rnd, dbase, 17);
        do_accept(wr, a, len, be);
        k = 0;
        while (!burst_done && k < 400) begin
            WD_VALID = (wd_q.size() > 0) && ($urandom_range(99) < 32'(wd_pct));
            WD_DATA  = WD_VALID ? wd_q[0] : $urandom;
            case (rd_mode)
                0:       RD_READY = 1;
                1:       RD_READY = (k % 4 == 0) || (k % 4 == 3);
                default: RD_READY = 1'($urandom);
            endcase
            @(negedge CLK);
            hs = WD_VALID && WD_READY;
            @(posedge CLK);
            if (hs) void'(wd_q.pop_front());
            #1;
            k++;
        end
        chk("burst_timeout", 32'(burst_done), 32'h1);
        WD_VALID = 0; RD_READY = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("acc_left", 32'(exp_acc.size()), 32'h0);
        chk("rd_left", 32'(exp_rd.size()), 32'h0);
        chk("wd_left", 32'(wd_q.size()), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected $finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        int hs_n;
        bit hs;
        REQ_VALID = 0; REQ_WRITE = 0; REQ_ADDR = 0; REQ_LEN = 0; REQ_BE = 0;
        WD_VALID = 0; WD_DATA = 0; RD_READY = 0;
        for (int i = 0; i < 65536; i++) begin
            v = $urandom;
            sram[i] = v;
            ref_mem[i] = v;
        end

        // Reset values while held in reset
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_req_ready", 32'(REQ_READY), 32'h1);
        chk("rst_wd_ready", 32'(WD_READY), 32'h0);
        chk("rst_rd_valid", 32'(RD_VALID), 32'h0);
        chk("rst_rd_last", 32'(RD_LAST), 32'h0);
        chk("rst_done", 32'(DONE), 32'h0);
        chk("rst_cs", 32'(CS), 32'h0);
        chk("rst_we", 32'(WE), 32'h0);
        chk("rst_rd_data", RD_DATA, 32'h0);
        chk("rst_wdata", WDATA, 32'h0);
        chk("rst_address", 32'(ADDRESS), 32'h0);
        chk("rst_err", 32'(ERR), 32'h0);
        @(posedge CLK);
        #1;
        RSTn = 1;
        chk("first_cycle_req_ready", 32'(REQ_READY), 32'h1);

        // Write 0xA0..0xA3 to 0x10..0x13 with continuous write data
        run_burst(1, 16'h0010, 4'd3, 4'hF, 0, 32'hA0, 100, 0);
        chk("wr_cs_count", 32'(cs_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("wr_cs_addr", 32'(cs_log[i]), 32'h10 + 32'(i));
            chk("wr_mem", sram[16'h0010 + 16'(i)], 32'hA0 + 32'(i));
        end

        // Read them back at full throughput
        run_burst(0, 16'h0010, 4'd3, 4'h0, 0, 32'h0, 100, 0);
        chk("rd_count", 32'(rd_log.size()), 32'd4);
        if (rd_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("rd_lit", rd_log[i], 32'hA0 + 32'(i));
            chk("rd_back_to_back", 32'(rd_cyc[3] - rd_cyc[0]), 32'd3);
        end

        // Same read under a 1,0,0,1 ready pattern
        run_burst(0, 16'h0010, 4'd3, 4'h0, 0, 32'h0, 100, 1);
        chk("stall_count", 32'(rd_log.size()), 32'd4);
        if (rd_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("stall_lit", rd_log[i], 32'hA0 + 32'(i));

        // Byte-lane write, then an all-masked write that must not touch the SRAM
        sram[16'h0040] = 32'hFFFF_FFFF;
        ref_mem[16'h0040] = 32'hFFFF_FFFF;
        run_burst(1, 16'h0040, 4'd0, 4'h2, 0, 32'h1234_5678, 100, 0);
        run_burst(0, 16'h0040, 4'd0, 4'h0, 0, 32'h0, 100, 2);
        chk("be_count", 32'(rd_log.size()), 32'd1);
        if (rd_log.size() == 1) chk("be_lane1", rd_log[0], 32'hFFFF_56FF);
        run_burst(1, 16'h0040, 4'd1, 4'h0, 0, 32'h5555_AAAA, 60, 0);
        chk("be0_no_cs", 32'(cs_cnt), 32'h0);
        chk("be0_mem", sram[16'h0040], 32'hFFFF_56FF);

        // Read across the top of the address space
        run_burst(0, 16'hFFFE, 4'd3, 4'h0, 0, 32'h0, 100, 0);
`ifdef SRAM_MASTER_BOUND_ERR_EN
        chk("bound_err_pulses", 32'(err_cnt), 32'd1);
        chk("bound_no_cs", 32'(cs_cnt), 32'd0);
`else
        chk("wrap_cs_count", 32'(cs_log.size()), 32'd4);
        if (cs_log.size() == 4) begin
            chk("wrap_addr0", 32'(cs_log[0]), 32'hFFFE);
            chk("wrap_addr1", 32'(cs_log[1]), 32'hFFFF);
            chk("wrap_addr2", 32'(cs_log[2]), 32'h0000);
            chk("wrap_addr3", 32'(cs_log[3]), 32'h0001);
        end
`endif

        // Randomized bursts, some placed near the top of memory
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            a = ($urandom_range(3) == 0) ? 16'hFFF0 + 16'($urandom_range(15)) : 16'($urandom);
            run_burst(1'($urandom), a, 4'($urandom), 4'($urandom), 1, 32'h0,
                      int'($urandom_range(100, 30)), 2);
        end

        // Reset after the second beat of an 8-beat write
        model_burst(1, 16'h0200, 4'd7, 4'hF, 1, 32'h0, 2);
        do_accept(1, 16'h0200, 4'd7, 4'hF);
        hs_n = 0;
        for (int k = 0; k < 50; k++) begin
            WD_VALID = 1;
            WD_DATA  = wd_q[0];
            @(negedge CLK);
            hs = WD_VALID && WD_READY;
            @(posedge CLK);
            if (hs) begin
                void'(wd_q.pop_front());
                hs_n++;
            end
            if (hs_n == 2) break;
            #1;
        end
        #1;
        RSTn = 0;
        #1;
        chk("midrst_cs", 32'(CS), 32'h0);
        chk("midrst_we", 32'(WE), 32'h0);
        chk("midrst_done", 32'(DONE), 32'h0);
        wd_q.delete();
        wr_beats_left = 0; busy_wr = 0; busy_rd = 0;
        done_due = -100; stall_prev = 0; rd_first_pending = 0;
        WD_VALID = 0;
        @(posedge CLK);
        #1;
        RSTn = 1;
        chk("midrst_req_ready", 32'(REQ_READY), 32'h1);
        repeat (5) @(posedge CLK);
        #1;
        chk("midrst_acc_left", 32'(exp_acc.size()), 32'h0);
        for (int i = 0; i < 8; i++)
            chk("midrst_mem", sram[16'h0200 + 16'(i)], ref_mem[16'h0200 + 16'(i)]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
